// File: rtl/muldiv_pkg.sv
// Shared types for the iterative M-extension multiply/divide unit.
// The decoder uses FUNCT7_MULDIV to route instructions here.
package muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle for muldiv_unit.
interface muldiv_if #(
  parameter int XLEN = 32
) ();
  // start is taken only while the unit is idle or finishing (busy=0) and flush=0;
  // it is ignored while busy=1. done pulses for one cycle when Result is new,
  // and Result holds until the next done. flush aborts and beats start.
  logic            start;
  logic            flush;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  modport master (
    output start, flush, Funct3, SrcA, SrcB,
    input  busy, done, Result
  );

  modport slave (
    input  start, flush, Funct3, SrcA, SrcB,
    output busy, done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply and restoring divide
// over XLEN steps through one shared adder/subtractor, then a sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_if.slave       bus,
  output muldiv_state_e state_dbg
);

  localparam int              CW   = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_in;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   addend_q;
  logic [2*XLEN-1:0] prod_q;
  logic              neg_q_q, neg_r_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  logic              accept, is_div_in, is_div;
  logic              sa, sb, div0, ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_val;
  logic [XLEN:0]     add_a;
  logic [XLEN+1:0]   add_res;
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  // Request decode: signs, magnitudes and the cases that skip iteration.
  always_comb begin
    op_in     = muldiv_op_e'(bus.Funct3);
    accept    = (state_q == IDLE || state_q == DONE) && bus.start && !bus.flush;
    is_div_in = op_in inside {DIV, DIVU, REM, REMU};
    sa        = (op_in inside {MULH, MULHSU, DIV, REM}) && bus.SrcA[XLEN-1];
    sb        = (op_in inside {MULH, DIV, REM}) && bus.SrcB[XLEN-1];
    mag_a     = sa ? -bus.SrcA : bus.SrcA;
    mag_b     = sb ? -bus.SrcB : bus.SrcB;
    div0      = is_div_in && (bus.SrcB == '0);
    ovf       = (op_in inside {DIV, REM}) && (bus.SrcA == MINV) && (bus.SrcB == '1);
    special   = div0 || ovf;
    if (div0) special_val = bus.Funct3[1] ? bus.SrcA : '1;
    else      special_val = bus.Funct3[1] ? '0 : bus.SrcA;
  end

  // Shared adder: adds the multiplicand to the high half, or trial-subtracts
  // the divisor from the left-shifted partial remainder (XLEN+1 bits wide).
  always_comb begin
    is_div = op_q inside {DIV, DIVU, REM, REMU};
    add_a  = is_div ? prod_q[2*XLEN-1:XLEN-1] : {1'b0, prod_q[2*XLEN-1:XLEN]};
    if (is_div) add_res = {1'b0, add_a} - {2'b00, addend_q};
    else        add_res = {1'b0, add_a} + {2'b00, addend_q};

    if (is_div) begin
      if (add_res[XLEN+1]) prod_step = {prod_q[2*XLEN-2:0], 1'b0};
      else                 prod_step = {add_res[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end else begin
      if (prod_q[0]) prod_step = {add_res[XLEN:0], prod_q[XLEN-1:1]};
      else           prod_step = {1'b0, prod_q[2*XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q_q ? -prod_q : prod_q;
    quot_fix = neg_q_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_fix  = neg_r_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    case (op_q)
      MUL:                  fix_val = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:            fix_val = quot_fix;
      default:              fix_val = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept)               state_d = special ? DONE : CALC;
        else if (state_q == DONE) state_d = IDLE;
      end
      CALC:    if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      cnt_q    <= '0;
      addend_q <= '0;
      prod_q   <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == CALC) || (state_d == FIX);
      done_q  <= (state_d == DONE);
      if (accept) begin
        op_q     <= op_in;
        cnt_q    <= '0;
        addend_q <= is_div_in ? mag_b : mag_a;
        prod_q   <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
        neg_q_q  <= sa ^ sb;
        neg_r_q  <= sa;
        if (special) result_q <= special_val;
      end else if (state_q == CALC) begin
        prod_q <= prod_step;
        if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == FIX && !bus.flush) result_q <= fix_val;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.Result = result_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic          clk = 1'b0;
  logic          reset;
  muldiv_state_e state_dbg;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f,
                                                 input logic [XLEN-1:0] a, b);
    longint    sa, sb, ps;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ref_result = '0;
    case (f)
      3'd0: ref_result = a * b;
      3'd1: begin ps = sa * sb; ref_result = ps[63:32]; end
      3'd2: begin ps = sa * longint'({32'b0, b}); ref_result = ps[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; ref_result = pu[63:32]; end
      3'd4: ref_result = (b == 0) ? '1 : 32'(sa / sb);
      3'd5: ref_result = (b == 0) ? '1 : a / b;
      3'd6: ref_result = (b == 0) ? a : 32'(sa % sb);
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] f, input logic [XLEN-1:0] a, b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns just after the accept edge (cycle 0).
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, b);
    bus.Funct3 = f;
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Steps cycle by cycle to the expected done cycle; ends on that cycle's negedge.
  task automatic finish_op(input string tag, input bit special, input int inject_at);
    int last;
    logic [XLEN-1:0] exp;
    last = special ? 1 : XLEN + 2;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (inject_at == k) begin
        bus.start  = 1'b1;
        bus.Funct3 = 3'b100;
        bus.SrcA   = 32'd5;
        bus.SrcB   = 32'd0;
      end else if (inject_at != 0 && k == inject_at + 1) begin
        bus.start = 1'b0;
      end
      check($sformatf("%s/busy@%0d", tag, k), 64'(bus.busy), 64'(!special && k <= XLEN + 1));
      check($sformatf("%s/done@%0d", tag, k), 64'(bus.done), 64'(k == last));
    end
    if (exp_q.size() == 0) begin
      check($sformatf("%s/scoreboard", tag), 64'(0), 64'(1));
    end else begin
      exp  = exp_q.pop_front();
      held = exp;
      check($sformatf("%s/result", tag), 64'(bus.Result), 64'(exp));
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check($sformatf("%s/busy", tag), 64'(bus.busy), 64'(0));
    check($sformatf("%s/done", tag), 64'(bus.done), 64'(0));
    check($sformatf("%s/state", tag), 64'(state_dbg), 64'(IDLE));
  endtask

  task automatic directed(input string tag, input logic [2:0] f,
                          input logic [XLEN-1:0] a, b, exp, input bit special);
    exp_q.push_back(exp);
    issue(f, a, b);
    finish_op(tag, special, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]      f;
    logic [XLEN-1:0] a, b;

    reset = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.Funct3 = 3'b000;
    bus.SrcA = '0; bus.SrcB = '0;
    held = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset/busy",   64'(bus.busy),   64'(0));
    check("reset/done",   64'(bus.done),   64'(0));
    check("reset/result", 64'(bus.Result), 64'(0));
    check("reset/state",  64'(state_dbg),  64'(IDLE));

    directed("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    idle_check("after_mul");

    directed("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    directed("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    directed("mulhsu_ones",3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    directed("div_-7/2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    directed("rem_-7/2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    directed("divu_f9/2",  3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);
    directed("remu_f9/2",  3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 1'b0);

    directed("div_5/0",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    directed("rem_5/0",    3'b110, 32'd5, 32'd0, 32'd5, 1'b1);
    directed("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    directed("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    idle_check("after_special");

    // A second start while busy must be dropped.
    exp_q.push_back(32'd142);
    issue(3'b101, 32'd1000, 32'd7);
    finish_op("start_in_calc", 1'b0, 5);
    idle_check("after_ignored");

    // Flush in cycle 10: no done, Result keeps the last completed value.
    issue(3'b000, 32'h1234, 32'h10);
    for (int k = 1; k <= XLEN + 4; k++) begin
      @(negedge clk);
      if (k == 10) bus.flush = 1'b1;
      if (k == 11) begin
        bus.flush = 1'b0;
        check("flush/busy@11", 64'(bus.busy), 64'(0));
      end
      check($sformatf("flush/done@%0d", k), 64'(bus.done), 64'(0));
    end
    check("flush/result_held", 64'(bus.Result), 64'(held));
    directed("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0);
    idle_check("after_mul_3x4");

    // start and flush together: flush wins.
    bus.Funct3 = 3'b000; bus.SrcA = 32'd2; bus.SrcB = 32'd2;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0;
    idle_check("start_flush_1");
    idle_check("start_flush_2");
    check("start_flush/result", 64'(bus.Result), 64'(held));

    // Reset in the middle of CALC.
    issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset/busy",   64'(bus.busy),   64'(0));
    check("midreset/done",   64'(bus.done),   64'(0));
    check("midreset/result", 64'(bus.Result), 64'(0));
    held = '0;

    // Back-to-back: second start lands in the DONE cycle.
    directed("b2b_first",  3'b000, 32'd3, 32'd5, 32'd15, 1'b0);
    directed("b2b_second", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
    idle_check("after_b2b");

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      exp_q.push_back(ref_result(f, a, b));
      issue(f, a, b);
      finish_op($sformatf("rand%0d_f%0d_%h_%h", i, f, a, b), ref_special(f, a, b), 0);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d_idle", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M/RV64M multiply-divide unit sitting in the execute stage beside the single-cycle ALU. It executes the eight M-extension operations (Funct7 = 0000001), selected by Funct3, using a shift-add multiplier and a restoring divider over XLEN iterations. While busy, it holds the pipeline through `busy`. A flush input lets the hazard unit abort an in-flight operation on a branch mispredict.

## Interface
- XLEN, 32, operand/result width; must be a power of two, 8 or more.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request valid; sampled only when accepted (see Operation).
- flush  in  1  abort current operation.
- Funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  XLEN  rs1 operand (multiplicand/dividend).
- SrcB  in  XLEN  rs2 operand (multiplier/divisor).
- busy  out  1  operation in flight; drives the pipeline stall.
- done  out  1  one-cycle pulse; Result valid.
- Result  out  XLEN  result; holds its value until the next done.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Accept:** start is accepted when state is IDLE or DONE and flush=0. On accept, the block latches Funct3, the operands, the signs and the magnitudes. start in CALC/FIX is ignored.
- **Signedness:**
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats SrcA as signed and SrcB as unsigned.
  - MUL and the U variants are unsigned in magnitude.
  - MUL's low half is identical for signed and unsigned.
- **Multiply:**
  - CALC runs XLEN shift-add steps into a 2·XLEN product register.
  - FIX negates the product if the operand signs differ.
  - Result = low half for MUL, high half otherwise.
- **Divide:**
  - CALC runs XLEN restoring steps, producing quotient and remainder magnitudes.
  - FIX applies signs: quotient negated if the signs differ (signed ops), remainder takes the sign of SrcA.
- **Special cases** (decided in IDLE, go straight to DONE, no CALC):
  - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give SrcA.
  - Signed overflow (DIV/REM with SrcA = 100…0 and SrcB = all-ones): DIV gives SrcA; REM gives 0.
- **Transitions:**
  - IDLE/DONE on accept → CALC, or → DONE for special cases.
  - CALC → FIX when the iteration counter reaches XLEN−1.
  - FIX → DONE.
  - DONE without start → IDLE.
- **Flush:** in any state, next state is IDLE. No done pulse; Result is unchanged. flush and start in the same cycle: flush wins and start is dropped.
- **Reset:** overrides everything, including mid-operation. Reset values: state IDLE, busy=0, done=0, Result=0, counter=0.
- **Arithmetic:** all internal arithmetic is modulo 2^XLEN per register. The counter is $clog2(XLEN) bits and wraps only by returning to 0 on accept.

## Timing
- Accept edge = cycle 0.
- **Normal ops:**
  - busy=1 in cycles 1..XLEN+1 (CALC for XLEN cycles, then FIX).
  - done=1 and Result valid in cycle XLEN+2 (state DONE, busy=0).
  - Total latency is XLEN+2 cycles (34 at XLEN=32).
- **Special cases:** done=1 in cycle 1, with busy=0 throughout.
- **Back-to-back:** start asserted in the DONE cycle is accepted, so there are zero idle cycles between operations.
- busy is registered and derived from state (CALC or FIX). done is registered and derived from state == DONE.
- Result updates only at the transition into DONE.

## Structure
- Package `muldiv_pkg` holds:
  - `muldiv_op_e` (the Funct3 enum above);
  - `muldiv_state_e` (IDLE, CALC, FIX, DONE);
  - the constant `FUNCT7_MULDIV = 7'b0000001`, which the decoder uses to route to this block.
- The block is a single module with no sub-module; the shared adder/subtractor serves both the multiply and divide paths.

## Test plan
Cycle counts are at XLEN = 32.
- MUL 7 × 0xFFFFFFFD (−3) → Result 0xFFFFFFEB; done exactly 34 cycles after the accept edge; busy high for cycles 1–33.
- Multiply high halves:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - REMU → 1.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - All four give done in cycle 1 with busy never high.
- Control:
  - Second start during CALC → ignored; the first result is unchanged.
  - flush in cycle 10 → busy=0 in cycle 11, no done, Result keeps its previous value.
  - A new MUL 3×4 afterwards → 12.
- Reset and back-to-back:
  - reset asserted mid-CALC → next cycle busy=0, done=0, Result=0.
  - Back-to-back start in the DONE cycle → second result is correct, 34 cycles later.
